// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that serialises set/reset/hold commands from NREQ requesters
// onto a shared bank of SR flags, so that S and R can never both reach one flag.
module sr_flag_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDX_W = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_i,
  input  logic [2*NREQ-1:0]       op_i,
  input  logic [IDX_W*NREQ-1:0]   idx_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [NREQ-1:0]         ack_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic [NFLAG-1:0]        q_o,
  output logic [NFLAG-1:0]        qn_o
);

  localparam int WID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, APPLY, ACK} state_e;

  state_e               state_q, state_d;
  logic [WID_W-1:0]     winner_q, winner_d;
  logic [WID_W-1:0]     rrPtr_q, rrPtr_d;
  logic [1:0]           opLat_q, opLat_d;
  logic [IDX_W-1:0]     idxLat_q, idxLat_d;
  logic [NFLAG-1:0]     q_q, q_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      ack_q, ack_d;
  logic                 err_q, err_d;

  logic                 pickValid;
  logic [WID_W-1:0]     pickId;
  logic [1:0]           pickOp;
  logic [IDX_W-1:0]     pickIdx;
  logic                 errFlag;
  logic                 flagEn;
  logic [NFLAG-1:0]     setStrobe, rstStrobe;

  function automatic logic [NREQ-1:0] oneHot(input logic [WID_W-1:0] id);
    logic [NREQ-1:0] v;
    v = '0;
    for (int k = 0; k < NREQ; k++) v[k] = (int'(id) == k);
    return v;
  endfunction

  // Search starts at rrPtr_q and wraps; the first requester found wins.
  always_comb begin
    int cand;
    cand      = 0;
    pickValid = 1'b0;
    pickId    = '0;
    pickOp    = '0;
    pickIdx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(rrPtr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!pickValid && req_i[cand]) begin
        pickValid = 1'b1;
        pickId    = WID_W'(cand);
        pickOp    = op_i[2*cand +: 2];
        pickIdx   = idx_i[IDX_W*cand +: IDX_W];
      end
    end
  end

  always_comb begin
    errFlag   = (opLat_q == 2'b11) || (int'(idxLat_q) >= NFLAG);
    flagEn    = (state_q == APPLY) && !errFlag;
    setStrobe = '0;
    rstStrobe = '0;
    for (int f = 0; f < NFLAG; f++) begin
      setStrobe[f] = flagEn && (int'(idxLat_q) == f) && (opLat_q == 2'b10);
      rstStrobe[f] = flagEn && (int'(idxLat_q) == f) && (opLat_q == 2'b01);
    end
  end

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    rrPtr_d  = rrPtr_q;
    opLat_d  = opLat_q;
    idxLat_d = idxLat_q;
    q_d      = (q_q | setStrobe) & ~rstStrobe;
    gnt_d    = '0;
    ack_d    = '0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickValid) begin
          winner_d = pickId;
          opLat_d  = pickOp;
          idxLat_d = pickIdx;
          gnt_d    = oneHot(pickId);
          state_d  = GRANT;
        end
      end
      GRANT: state_d = APPLY;
      APPLY: begin
        ack_d   = oneHot(winner_q);
        err_d   = errFlag;
        state_d = ACK;
      end
      ACK: begin
        if (int'(winner_q) == NREQ - 1) rrPtr_d = '0;
        else                            rrPtr_d = winner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      winner_q <= '0;
      rrPtr_q  <= '0;
      opLat_q  <= '0;
      idxLat_q <= '0;
      q_q      <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      rrPtr_q  <= rrPtr_d;
      opLat_q  <= opLat_d;
      idxLat_q <= idxLat_d;
      q_q      <= q_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE);
  assign q_o    = q_q;
  assign qn_o   = ~q_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter: reset, single set, fairness, set/reset
// conflict, illegal commands and reset during a transaction.
module tb_sr_flag_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [15:0] idx;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        err;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  qn;

  int vecs;
  int miscompares;

  sr_flag_arbiter #(.NREQ(4), .NFLAG(8), .IDX_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .idx_i(idx),
    .gnt_o(gnt), .ack_o(ack), .err_o(err), .busy_o(busy), .q_o(q), .qn_o(qn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants checked every cycle while out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      vecs++;
      if (!$onehot0(gnt) || !$onehot0(ack) || (qn !== ~q) ||
          ((dut.setStrobe & dut.rstStrobe) !== 8'h00)) begin
        miscompares++;
        $display("FAIL invariant: gnt=%b ack=%b q=%h qn=%h required onehot0 grants/acks, qn=~q, no S=R=1",
                 gnt, ack, q, qn);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 4'b1111;
    op    = 8'h00;
    idx   = 16'h0000;
    tick();
    tick();
    vecs++; if (q !== 8'h00)    begin miscompares++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
    vecs++; if (qn !== 8'hFF)   begin miscompares++; $display("FAIL reset_qn: got %h expected %h", qn, 8'hFF); end
    vecs++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000); end
    vecs++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack: got %b expected %b", ack, 4'b0000); end
    vecs++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b expected %b", busy, 1'b0); end
    vecs++; if (err !== 1'b0)   begin miscompares++; $display("FAIL reset_err: got %b expected %b", err, 1'b0); end
    rst_n = 1'b1;
    tick();
    vecs++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL reset_first_gnt: got %b expected %b", gnt, 4'b0001); end
    req = 4'b0000;
    tick();
    tick();
    vecs++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL reset_hold_ack: got %b expected %b", ack, 4'b0001); end
    vecs++; if (q !== 8'h00)    begin miscompares++; $display("FAIL reset_hold_q: got %h expected %h", q, 8'h00); end
    tick();
  endtask

  task automatic test_single_set;
    req = 4'b0001;
    op  = 8'b0000_0010;
    idx = 16'h0005;
    tick();
    vecs++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL set_gnt: got %b expected %b", gnt, 4'b0001); end
    vecs++; if (busy !== 1'b1)  begin miscompares++; $display("FAIL set_busy: got %b expected %b", busy, 1'b1); end
    req = 4'b0000;
    tick();
    vecs++; if (gnt !== 4'b0000) begin miscompares++; $display("FAIL set_gnt_drop: got %b expected %b", gnt, 4'b0000); end
    vecs++; if (q !== 8'h00)    begin miscompares++; $display("FAIL set_q_early: got %h expected %h", q, 8'h00); end
    tick();
    vecs++; if (q !== 8'h20)    begin miscompares++; $display("FAIL set_q: got %h expected %h", q, 8'h20); end
    vecs++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL set_ack: got %b expected %b", ack, 4'b0001); end
    vecs++; if (err !== 1'b0)   begin miscompares++; $display("FAIL set_err: got %b expected %b", err, 1'b0); end
    tick();
    vecs++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL set_idle: got %b expected %b", busy, 1'b0); end
    vecs++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL set_ack_pulse: got %b expected %b", ack, 4'b0000); end
  endtask

  task automatic test_fairness;
    logic [3:0] expG;
    logic [7:0] expQ;
    doReset();
    req  = 4'b1111;
    op   = 8'b1010_1010;
    idx  = {4'd3, 4'd2, 4'd1, 4'd0};
    expQ = 8'h00;
    for (int g = 0; g < 4; g++) begin
      expG = 4'b0001 << g;
      expQ = expQ | (8'h01 << g);
      tick();
      vecs++; if (gnt !== expG) begin miscompares++; $display("FAIL fair_gnt%0d: got %b expected %b", g, gnt, expG); end
      tick();
      tick();
      vecs++; if (ack !== expG) begin miscompares++; $display("FAIL fair_ack%0d: got %b expected %b", g, ack, expG); end
      vecs++; if (q !== expQ)   begin miscompares++; $display("FAIL fair_q%0d: got %h expected %h", g, q, expQ); end
      tick();
    end
    vecs++; if (q !== 8'h0F) begin miscompares++; $display("FAIL fair_final_q: got %h expected %h", q, 8'h0F); end
    req = 4'b0010;
    tick();
    vecs++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL fair_gnt_r1: got %b expected %b", gnt, 4'b0010); end
    req = 4'b0101;
    tick();
    tick();
    tick();
    tick();
    vecs++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL fair_gnt_r2_first: got %b expected %b", gnt, 4'b0100); end
    tick();
    tick();
    tick();
    tick();
    vecs++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL fair_gnt_r0_wrap: got %b expected %b", gnt, 4'b0001); end
    req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  task automatic test_conflict;
    doReset();
    req = 4'b0110;
    op  = 8'b0001_1000;
    idx = {4'd0, 4'd3, 4'd3, 4'd0};
    tick();
    vecs++; if (gnt !== 4'b0010) begin miscompares++; $display("FAIL conf_gnt1: got %b expected %b", gnt, 4'b0010); end
    tick();
    tick();
    vecs++; if (q !== 8'h08)    begin miscompares++; $display("FAIL conf_q_set: got %h expected %h", q, 8'h08); end
    vecs++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL conf_ack1: got %b expected %b", ack, 4'b0010); end
    tick();
    tick();
    vecs++; if (gnt !== 4'b0100) begin miscompares++; $display("FAIL conf_gnt2: got %b expected %b", gnt, 4'b0100); end
    tick();
    tick();
    vecs++; if (q !== 8'h00)    begin miscompares++; $display("FAIL conf_q_reset: got %h expected %h", q, 8'h00); end
    vecs++; if (ack !== 4'b0100) begin miscompares++; $display("FAIL conf_ack2: got %b expected %b", ack, 4'b0100); end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_illegal;
    req = 4'b0001;
    op  = 8'b0000_0011;
    idx = 16'h0002;
    tick();
    req = 4'b0000;
    tick();
    tick();
    vecs++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL ill_op_ack: got %b expected %b", ack, 4'b0001); end
    vecs++; if (err !== 1'b1)   begin miscompares++; $display("FAIL ill_op_err: got %b expected %b", err, 1'b1); end
    vecs++; if (q !== 8'h00)    begin miscompares++; $display("FAIL ill_op_q: got %h expected %h", q, 8'h00); end
    tick();
    vecs++; if (err !== 1'b0)   begin miscompares++; $display("FAIL ill_err_pulse: got %b expected %b", err, 1'b0); end
    req = 4'b0001;
    op  = 8'b0000_0010;
    idx = 16'h0009;
    tick();
    req = 4'b0000;
    tick();
    tick();
    vecs++; if (ack !== 4'b0001) begin miscompares++; $display("FAIL ill_idx_ack: got %b expected %b", ack, 4'b0001); end
    vecs++; if (err !== 1'b1)   begin miscompares++; $display("FAIL ill_idx_err: got %b expected %b", err, 1'b1); end
    vecs++; if (q !== 8'h00)    begin miscompares++; $display("FAIL ill_idx_q: got %h expected %h", q, 8'h00); end
    tick();
  endtask

  task automatic test_reset_mid_op;
    req = 4'b0001;
    op  = 8'b0000_0010;
    idx = 16'h0007;
    tick();
    req = 4'b0000;
    tick();
    rst_n = 1'b0;
    tick();
    vecs++; if (q !== 8'h00)    begin miscompares++; $display("FAIL mid_q: got %h expected %h", q, 8'h00); end
    vecs++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL mid_ack: got %b expected %b", ack, 4'b0000); end
    vecs++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL mid_busy: got %b expected %b", busy, 1'b0); end
    rst_n = 1'b1;
    tick();
    vecs++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL mid_no_late_ack: got %b expected %b", ack, 4'b0000); end
    vecs++; if (q !== 8'h00)    begin miscompares++; $display("FAIL mid_no_late_q: got %h expected %h", q, 8'h00); end
    req = 4'b1111;
    op  = 8'h00;
    tick();
    vecs++; if (gnt !== 4'b0001) begin miscompares++; $display("FAIL mid_rrptr: got %b expected %b", gnt, 4'b0001); end
    req = 4'b0000;
    tick();
    tick();
    tick();
  endtask

  initial begin
    vecs        = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    req         = 4'b0000;
    op          = 8'h00;
    idx         = 16'h0000;
    test_reset();
    test_single_set();
    test_fairness();
    test_conflict();
    test_illegal();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
- Round-robin arbiter that shares one bank of SR flag bits between NREQ requesters.
- Each requester issues set, reset or hold commands on one flag index through a req/gnt/ack handshake.
- The block sequences the per-flag S, R and en strobes internally, so only one command touches the bank at a time. The forbidden S=R=1 case can never reach the bank.
- Sits between control agents and the status-flag bank; q/qn feed downstream logic.

Parameters:
NREQ, 4, number of requesters (2..8)
NFLAG, 8, number of SR flag bits in the bank
IDX_W, 3, flag index width; must satisfy 2**IDX_W >= NFLAG

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
req  input  NREQ  request per requester, level
op  input  2*NREQ  command per requester, bits [2i+1:2i]: 00 hold, 01 reset, 10 set, 11 illegal
idx  input  IDX_W*NREQ  target flag per requester, bits [IDX_W*i +: IDX_W]
gnt  output  NREQ  one-hot grant, registered
ack  output  NREQ  one-hot completion pulse, 1 cycle
err  output  1  pulse with ack when command was illegal or idx >= NFLAG
busy  output  1  high when state != IDLE
q  output  NFLAG  flag bank state
qn  output  NFLAG  always ~q

Behaviour:
- Reset: synchronous, active-low, sampled on clk rising edge. Applies from any state, including mid-transaction.
  - state=IDLE, q=0, qn=all ones, gnt=0, ack=0, err=0, busy=0, rr_ptr=0.
  - An in-flight command is dropped: no ack, q not modified.
- FSM states: IDLE, GRANT, APPLY, ACK; one cycle each except IDLE.
- IDLE:
  - If req != 0, choose the winner by round-robin starting at rr_ptr: rr_ptr, rr_ptr+1, ... mod NREQ; first set bit wins.
  - Latch the winner id, its op and idx; go to GRANT.
  - If req == 0, stay in IDLE.
- GRANT: gnt[winner]=1 for exactly this cycle; go to APPLY.
- APPLY:
  - Internal strobes en=1 on the latched idx.
  - op 10: S=1, R=0. op 01: S=0, R=1. op 00: both 0.
  - op 11 or idx >= NFLAG: S=R=0, en=0, mark error.
  - Bank update occurs at this clock edge. Go to ACK.
- ACK:
  - ack[winner]=1 and err=error flag for this cycle.
  - The new q value is visible in this cycle.
  - rr_ptr = (winner+1) mod NREQ; go to IDLE.
- Latency: req sampled at edge N gives gnt high in cycle N+1, q update and ack in cycle N+3. The next grant can appear at N+5, so minimum transaction period is 4 cycles.
- Requester rules:
  - op and idx need only be valid in the cycle req is sampled in IDLE; they are latched.
  - Withdrawing req after sampling does not abort; ack still issues.
  - req still high in the IDLE cycle after ack is a new request.
- Non-winning requests stay pending, unaffected, until granted.
- Simultaneous requests: exactly one gnt bit; never two ack bits.
- S and R are never both 1 on any flag. Flags other than idx are never modified.
- rr_ptr advances only on a completed ACK, including illegal commands.
- qn is combinational ~q at all times; no X after reset.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> q=8'h00, qn=8'hFF, gnt=0, ack=0, busy=0. First grant after release goes to requester 0.
- Single set: req=4'b0001, op0=10, idx0=5 at edge N -> gnt=4'b0001 in N+1, q=8'h20 and ack=4'b0001 in N+3, err=0, busy=0 in N+4.
- Fairness: req=4'b1111 held, op=10, idx_i=i -> grants in order 0,1,2,3, each 4 cycles apart, final q=8'h0F. Then req=4'b0101 after a grant to 1 -> requester 2 granted before 0.
- Set/reset conflict: req1 set idx 3 and req2 reset idx 3 in the same cycle -> 1 serviced first (q[3]=1), then 2 (q[3]=0). S=R=1 never observed.
- Illegal: op0=11 idx0=2, then op0=10 idx0=9 with NFLAG=8 -> each gives ack=4'b0001 with err=1, and q unchanged.
- Reset mid-op: rst_n=0 in APPLY cycle of a set idx 7 -> next cycle q=8'h00, no ack, state IDLE, rr_ptr=0.
